ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 18 +
 rtl/ram_arbiter_rr_pick.sv | 27 ++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and sizing constants for the RAM arbiter.
package ram_arbiter_pkg;

    // Access-length counter width (ACC is limited to 1..15)
    localparam int CNT_W  = 4;

    // Default RAM geometry
    localparam int DEF_AW = 18;
    localparam int DEF_DW = 16;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible channel after 'last'.
module rr_pick #(
    parameter int NCH = 3,
    parameter int LW  = 2
) (
    input  logic [NCH-1:0] elig,
    input  logic [LW-1:0]  last,
    output logic [NCH-1:0] win,
    output logic           vld
);

    // Scan channels last+1, last+2, ... wrapping; the first eligible one wins
    always_comb begin
        int c;
        win = '0;
        vld = 1'b0;
        c   = 0;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(last) + k) % NCH;
            if (!vld && elig[c]) begin
                win[c] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-channel RAM arbiter: round-robin grant, fixed-length RAM access,
// one-cycle ack. Channel 0 (loader) is the only eligible one while initializing.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NCH = 3,
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int ACC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              initializing,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_we,
    output logic              ram_oe,
    input  logic [DW-1:0]     ram_rdata,
    output logic              busy
);

    localparam int              LW       = $clog2(NCH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    last_q, last_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic [NCH-1:0]   ack_q, ack_d;
    logic [AW-1:0]    ram_addr_q, ram_addr_d;
    logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
    logic             ram_we_q, ram_we_d;
    logic             ram_oe_q, ram_oe_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   pick_win;
    logic             pick_vld;
    logic             last_cyc;

    assign elig     = initializing ? (req & NCH'(1)) : req;
    assign last_cyc = (cnt_q == CNT_LAST);

    rr_pick #(.NCH(NCH), .LW(LW)) u_pick (
        .elig (elig),
        .last (last_q),
        .win  (pick_win),
        .vld  (pick_vld)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: arbitrate in IDLE, hold ACCESS for ACC cycles, one DONE cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pick_vld) state_d = ST_ACCESS;
            ST_ACCESS: if (last_cyc) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch the winner's request, count access, capture read data
    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;
        ram_oe_d    = ram_oe_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    cnt_d = '0;
                    gnt_d = pick_win;
                    for (int i = 0; i < NCH; i++) begin
                        if (pick_win[i]) begin
                            ram_addr_d  = addr[i*AW +: AW];
                            ram_wdata_d = wdata[i*DW +: DW];
                            ram_we_d    = we[i];
                            ram_oe_d    = !we[i];
                            // loader grants during init do not move the pointer
                            if (!initializing) last_d = LW'(i);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (last_cyc) begin
                    cnt_d    = '0;
                    ack_d    = gnt_q;
                    gnt_d    = '0;
                    ram_we_d = 1'b0;
                    ram_oe_d = 1'b0;
                    if (ram_oe_q) rdata_d = ram_rdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            last_q      <= LW'(NCH - 1);
            gnt_q       <= '0;
            ack_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (arbitration order, access timeline, memory).
module tb_ram_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int ACC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              initializing;
    logic [NCH-1:0]    req, we;
    logic [AW-1:0]     a_ch [NCH];
    logic [DW-1:0]     d_ch [NCH];
    logic [NCH*AW-1:0] addr_p;
    logic [NCH*DW-1:0] wdata_p;
    logic [NCH-1:0]    gnt, ack;
    logic [DW-1:0]     rdata, ram_wdata, ram_rdata;
    logic [AW-1:0]     ram_addr;
    logic              ram_we, ram_oe, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        addr_p  = '0;
        wdata_p = '0;
        for (int i = 0; i < NCH; i++) begin
            addr_p[i*AW +: AW]  = a_ch[i];
            wdata_p[i*DW +: DW] = d_ch[i];
        end
    end

    ram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ACC(ACC)) dut (
        .clk(clk), .rst(rst), .initializing(initializing),
        .req(req), .we(we), .addr(addr_p), .wdata(wdata_p),
        .gnt(gnt), .ack(ack), .rdata(rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM environment: 16 words selected by the low address nibble, cleared by rst
    logic [DW-1:0] ram_mem [16];
    assign ram_rdata = ram_mem[ram_addr[3:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
        end else if (ram_we) begin
            ram_mem[ram_addr[3:0]] <= ram_wdata;
        end
    end

    // Reference model: a transaction occupies phases 1..ACC (access), ACC+1 (ack)
    int            m_phase, m_owner, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_we;
    logic [DW-1:0] ref_mem [16];
    bit   [NCH-1:0] pend;

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_owner = -1; m_last = NCH - 1;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0;
            for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        end else if (m_phase == 0) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (m_owner < 0 && req[c] && (!initializing || c == 0)) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_phase = 1;
                m_addr  = a_ch[m_owner];
                m_wdata = d_ch[m_owner];
                m_we    = we[m_owner];
                if (!initializing) m_last = m_owner;
            end
        end else if (m_phase <= ACC) begin
            if (m_phase == ACC) begin
                if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
                else      m_rdata = ref_mem[m_addr[3:0]];
            end
            m_phase++;
        end else begin
            m_phase = 0;
            m_owner = -1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        logic [NCH-1:0] eg, ea;
        logic           acc_ph;
        acc_ph = (m_phase >= 1 && m_phase <= ACC);
        eg = '0;
        ea = '0;
        if (acc_ph) eg[m_owner] = 1'b1;
        if (m_phase == ACC + 1) ea[m_owner] = 1'b1;
        chk("gnt",       32'(gnt),       32'(eg));
        chk("ack",       32'(ack),       32'(ea));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("ram_we",    32'(ram_we),    32'(acc_ph && m_we));
        chk("ram_oe",    32'(ram_oe),    32'(acc_ph && !m_we));
        chk("ram_addr",  32'(ram_addr),  32'(m_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        chk("rdata",     32'(rdata),     32'(m_rdata));
        chk("we_oe_excl", 32'(ram_we & ram_oe), 32'd0);
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("ack_onehot", 32'($onehot0(ack)), 32'd1);
    endtask

    // One clock: model consumes the inputs the DUT will sample, then compare
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    task automatic drop_acked();
        if (m_phase == ACC + 1) begin
            req[m_owner]  = 1'b0;
            pend[m_owner] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cyc();
            drop_acked();
        end
    endtask

    task automatic issue(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[c]  = 1'b1;
        we[c]   = w;
        a_ch[c] = a;
        d_ch[c] = d;
        pend[c] = 1'b1;
    endtask

    // Run until the model acks channel ch; an expired bound counts as a failure
    task automatic wait_ack(input int ch, input int maxc, input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < maxc && !got; n++) begin
            cyc();
            if (m_phase == ACC + 1 && m_owner == ch) got = 1'b1;
            drop_acked();
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        logic [NCH-1:0] gseen [$];
        logic [NCH-1:0] gexp  [4];
        logic [NCH-1:0] gprev;
        logic [AW-1:0]  aset  [4];
        int             wecnt;
        bit             hit;

        rst = 1'b1; initializing = 1'b0; req = '0; we = '0; pend = '0;
        for (int i = 0; i < NCH; i++) begin a_ch[i] = '0; d_ch[i] = '0; end
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Round-robin order with all channels requesting continuously
        for (int i = 0; i < NCH; i++) issue(i, 1'b0, AW'(i), '0);
        gprev = '0;
        repeat (16) begin
            cyc();
            if (gnt != '0 && gprev == '0) gseen.push_back(gnt);
            gprev = gnt;
        end
        gexp = '{3'b001, 3'b010, 3'b100, 3'b001};
        chk("rr_count", 32'(gseen.size()), 32'd4);
        for (int i = 0; i < 4 && i < gseen.size(); i++) chk("rr_order", 32'(gseen[i]), 32'(gexp[i]));
        req = '0; pend = '0;
        run(6);

        // Initializing: only the loader may be granted
        initializing = 1'b1;
        issue(1, 1'b0, 18'h00001, '0);
        issue(2, 1'b0, 18'h00002, '0);
        run(20);
        issue(0, 1'b1, 18'h00010, 16'hBEEF);
        wecnt = 0;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            cyc();
            if (ram_we && ram_addr == 18'h00010) wecnt++;
            if (m_phase == ACC + 1 && m_owner == 0) hit = 1'b1;
            drop_acked();
        end
        chk("init_ack0", 32'(hit), 32'd1);
        chk("init_we_cycles", 32'(wecnt), 32'(ACC));
        run(3);
        initializing = 1'b0;
        run(12);
        req = '0; pend = '0;
        run(4);

        // Write then read the top address
        issue(1, 1'b1, 18'h3FFFF, 16'h1234);
        wait_ack(1, 20, "wr_top");
        issue(2, 1'b0, 18'h3FFFF, '0);
        wait_ack(2, 20, "rd_top");
        chk("rd_top_data", 32'(rdata), 32'h1234);
        run(2);
        issue(1, 1'b1, 18'h3FFFF, 16'h5555);
        wait_ack(1, 20, "wr_top2");
        run(2);
        chk("rd_hold", 32'(rdata), 32'h1234);

        // Reset in the second access cycle of a channel-1 write
        issue(1, 1'b1, 18'h00007, 16'hA5A5);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            cyc();
            if (m_phase == 2) hit = 1'b1;
        end
        chk("rst_reach_ph2", 32'(hit), 32'd1);
        rst = 1'b1;
        cyc();
        chk("rst_outs", 32'({gnt, ack, ram_we, ram_oe, busy}), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        rst = 1'b0;
        issue(2, 1'b0, 18'h00003, '0);
        cyc();
        chk("post_rst_gnt", 32'(gnt), 32'b010);
        run(12);
        req = '0; pend = '0;
        run(3);

        // Owner drops req and initializing toggles mid-access
        issue(2, 1'b0, 18'h00007, '0);
        cyc();
        req[2] = 1'b0;
        initializing = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 10 && !hit; n++) begin
            cyc();
            if (m_phase == ACC + 1 && m_owner == 2) begin
                hit = 1'b1;
                chk("drop_ack2", 32'(ack), 32'b100);
            end
        end
        chk("drop_done", 32'(hit), 32'd1);
        initializing = 1'b0;
        pend = '0;
        run(3);

        // Random traffic
        aset = '{18'h00000, 18'h00005, 18'h3FFFF, 18'h0000A};
        repeat (400) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c] && $urandom_range(0, 3) == 0)
                    issue(c, 1'($urandom_range(0, 1)), aset[$urandom_range(0, 3)], 16'($urandom));
            end
            if (m_phase >= 1 && m_phase < ACC + 1 && $urandom_range(0, 7) == 0) req[m_owner] = 1'b0;
            if ($urandom_range(0, 9) == 0) initializing = !initializing;
            cyc();
            drop_acked();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
